// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage of the 5-stage MIPS pipeline.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        REDIRECT = 2'd2
    } fetch_action_t;

endpackage

// File: rtl/pc_register.sv
// Program counter: async reset, hold on stall, load of a redirect target, else PC+4.
module pc_register
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        load,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (!hold) begin
            pc <= load ? target : pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, feeds instruction memory and fills the IF/ID register,
// honouring hazard stalls and decode-stage branch/jump redirects.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter bit          DELAY_SLOT = 1'b0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             FlushSignal,
    input  logic             BranchTaken,
    input  logic [31:0]      BranchTarget,
    input  logic             Jump,
    input  logic [31:0]      JumpTarget,
    output logic [31:0]      InstrMemAddr,
    input  logic [31:0]      InstrMemData,
    output logic [31:0]      IF_ID_Instr,
    output logic [31:0]      IF_ID_PCPlus4,
    output logic             IF_ID_Valid,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] SquashCount
);

    fetch_action_t action;
    logic [31:0]   redirect_target;
    logic [31:0]   pc;
    logic [31:0]   pc_plus4;
    logic          hold;
    logic          load;

    // Stall outranks redirect: the stalled decode instruction's operands are not valid yet.
    always_comb begin
        action = RUN;
        if (FlushSignal) begin
            action = STALL;
        end else if (Jump || BranchTaken) begin
            action = REDIRECT;
        end
    end

    assign redirect_target = Jump ? JumpTarget : BranchTarget;
    assign hold            = (action == STALL);
    assign load            = (action == REDIRECT);
    assign InstrMemAddr    = pc;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (Clk),
        .rst      (Rst),
        .hold     (hold),
        .load     (load),
        .target   (redirect_target),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            IF_ID_Instr   <= NOP_INSTR;
            IF_ID_PCPlus4 <= '0;
            IF_ID_Valid   <= 1'b0;
        end else if (action == RUN || (action == REDIRECT && DELAY_SLOT)) begin
            IF_ID_Instr   <= InstrMemData;
            IF_ID_PCPlus4 <= pc_plus4;
            IF_ID_Valid   <= 1'b1;
        end else if (action == REDIRECT) begin
            IF_ID_Instr   <= NOP_INSTR;
            IF_ID_PCPlus4 <= '0;
            IF_ID_Valid   <= 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            StallCount  <= '0;
            SquashCount <= '0;
        end else begin
            if (action == STALL && StallCount != '1) begin
                StallCount <= StallCount + CNT_W'(1);
            end
            if (action == REDIRECT && !DELAY_SLOT && SquashCount != '1) begin
                SquashCount <= SquashCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: three configurations driven in lockstep and checked against a
// transaction-level model every cycle, plus hand-computed spot checks.
module tb_fetch_stage;

    localparam logic [31:0] TAG = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;

    logic [31:0] addr  [3];
    logic [31:0] data  [3];
    logic [31:0] instr [3];
    logic [31:0] pc4   [3];
    logic        valid [3];
    logic [31:0] stall_cnt  [3];
    logic [31:0] squash_cnt [3];
    logic [15:0] st0, st1, sq0, sq1;
    logic [3:0]  st2, sq2;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_mem
        assign data[g] = addr[g] ^ TAG;
    end

    assign stall_cnt[0]  = {16'd0, st0};
    assign stall_cnt[1]  = {16'd0, st1};
    assign stall_cnt[2]  = {28'd0, st2};
    assign squash_cnt[0] = {16'd0, sq0};
    assign squash_cnt[1] = {16'd0, sq1};
    assign squash_cnt[2] = {28'd0, sq2};

    fetch_stage #(.RESET_PC(32'h0), .DELAY_SLOT(1'b0), .CNT_W(16)) dut0 (
        .Clk(clk), .Rst(rst), .FlushSignal(flush), .BranchTaken(branch),
        .BranchTarget(branch_target), .Jump(jump), .JumpTarget(jump_target),
        .InstrMemAddr(addr[0]), .InstrMemData(data[0]), .IF_ID_Instr(instr[0]),
        .IF_ID_PCPlus4(pc4[0]), .IF_ID_Valid(valid[0]), .StallCount(st0), .SquashCount(sq0));

    fetch_stage #(.RESET_PC(32'h0), .DELAY_SLOT(1'b1), .CNT_W(16)) dut1 (
        .Clk(clk), .Rst(rst), .FlushSignal(flush), .BranchTaken(branch),
        .BranchTarget(branch_target), .Jump(jump), .JumpTarget(jump_target),
        .InstrMemAddr(addr[1]), .InstrMemData(data[1]), .IF_ID_Instr(instr[1]),
        .IF_ID_PCPlus4(pc4[1]), .IF_ID_Valid(valid[1]), .StallCount(st1), .SquashCount(sq1));

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .DELAY_SLOT(1'b0), .CNT_W(4)) dut2 (
        .Clk(clk), .Rst(rst), .FlushSignal(flush), .BranchTaken(branch),
        .BranchTarget(branch_target), .Jump(jump), .JumpTarget(jump_target),
        .InstrMemAddr(addr[2]), .InstrMemData(data[2]), .IF_ID_Instr(instr[2]),
        .IF_ID_PCPlus4(pc4[2]), .IF_ID_Valid(valid[2]), .StallCount(st2), .SquashCount(sq2));

    // Model: per-configuration architectural state, advanced once per edge by the fetch rules.
    bit          m_ds   [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] m_rpc  [3] = '{32'h0, 32'h0, 32'hFFFF_FFFC};
    logic [31:0] m_max  [3] = '{32'hFFFF, 32'hFFFF, 32'hF};
    logic [31:0] m_pc   [3];
    logic [31:0] m_ins  [3];
    logic [31:0] m_pc4  [3];
    logic        m_val  [3];
    logic [31:0] m_st   [3];
    logic [31:0] m_sq   [3];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_pc[i] <= m_rpc[i]; m_ins[i] <= '0; m_pc4[i] <= '0;
                m_val[i] <= 1'b0; m_st[i] <= '0; m_sq[i] <= '0;
            end else if (flush) begin
                m_st[i] <= (m_st[i] < m_max[i]) ? m_st[i] + 1 : m_st[i];
            end else if (jump || branch) begin
                m_pc[i] <= jump ? jump_target : branch_target;
                if (m_ds[i]) begin
                    m_ins[i] <= m_pc[i] ^ TAG; m_pc4[i] <= m_pc[i] + 4; m_val[i] <= 1'b1;
                end else begin
                    m_ins[i] <= '0; m_pc4[i] <= '0; m_val[i] <= 1'b0;
                    m_sq[i] <= (m_sq[i] < m_max[i]) ? m_sq[i] + 1 : m_sq[i];
                end
            end else begin
                m_pc[i] <= m_pc[i] + 4;
                m_ins[i] <= m_pc[i] ^ TAG; m_pc4[i] <= m_pc[i] + 4; m_val[i] <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_addr%0d", i), addr[i], m_pc[i]);
                chk($sformatf("model_instr%0d", i), instr[i], m_ins[i]);
                chk($sformatf("model_pc4_%0d", i), pc4[i], m_pc4[i]);
                chk($sformatf("model_valid%0d", i), {31'd0, valid[i]}, {31'd0, m_val[i]});
                chk($sformatf("model_stall%0d", i), stall_cnt[i], m_st[i]);
                chk($sformatf("model_squash%0d", i), squash_cnt[i], m_sq[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 check_en = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("reset_addr0", addr[0], 32'h0);
        chk("reset_addr2", addr[2], 32'hFFFF_FFFC);
        chk("reset_valid0", {31'd0, valid[0]}, 32'd0);

        tick();
        chk("first_instr0", instr[0], 32'hC0DE_0000);
        chk("first_pc4_0", pc4[0], 32'h4);
        chk("first_valid0", {31'd0, valid[0]}, 32'd1);
        chk("wrap_addr2", addr[2], 32'h0);
        chk("wrap_pc4_2", pc4[2], 32'h0);

        tick();
        chk("run_addr0", addr[0], 32'h8);
        flush = 1'b1;
        tick();
        branch = 1'b1; branch_target = 32'h40;
        tick();
        chk("stall_addr0", addr[0], 32'h8);
        chk("stall_instr0", instr[0], 32'hC0DE_0004);
        chk("stall_count0", stall_cnt[0], 32'd2);
        flush = 1'b0; branch = 1'b0;
        tick();
        chk("resume_instr0", instr[0], 32'hC0DE_0008);
        chk("resume_addr0", addr[0], 32'hC);

        branch = 1'b1; branch_target = 32'h40;
        tick();
        branch = 1'b0;
        chk("squash_addr0", addr[0], 32'h40);
        chk("squash_instr0", instr[0], 32'h0);
        chk("squash_valid0", {31'd0, valid[0]}, 32'd0);
        chk("squash_count0", squash_cnt[0], 32'd1);
        chk("slot_instr1", instr[1], 32'hC0DE_000C);
        chk("slot_valid1", {31'd0, valid[1]}, 32'd1);
        chk("slot_squash1", squash_cnt[1], 32'd0);
        tick();
        chk("target_instr0", instr[0], 32'hC0DE_0040);
        chk("target_pc4_0", pc4[0], 32'h44);
        chk("target_instr1", instr[1], 32'hC0DE_0040);

        jump = 1'b1; jump_target = 32'h100; branch = 1'b1; branch_target = 32'h40;
        tick();
        jump = 1'b0; branch = 1'b0;
        chk("jump_wins_addr0", addr[0], 32'h100);
        chk("jump_squash0", squash_cnt[0], 32'd2);
        tick();
        jump = 1'b1; jump_target = 32'h200;
        tick();
        jump = 1'b0;
        tick(); tick();
        chk("jump_run_addr0", addr[0], 32'h208);

        flush = 1'b1;
        for (int i = 0; i < 21; i++) tick();
        chk("sat_stall2", stall_cnt[2], 32'hF);
        chk("long_stall0", stall_cnt[0], 32'd23);

        branch = 1'b1; branch_target = 32'h300;
        #2 rst = 1'b1;
        #1;
        chk("async_addr0", addr[0], 32'h0);
        chk("async_addr2", addr[2], 32'hFFFF_FFFC);
        chk("async_instr0", instr[0], 32'h0);
        chk("async_valid1", {31'd0, valid[1]}, 32'd0);
        chk("async_stall0", stall_cnt[0], 32'd0);
        chk("async_squash0", squash_cnt[0], 32'd0);
        tick();
        rst = 1'b0; flush = 1'b0; branch = 1'b0;
        tick();
        chk("post_reset_addr0", addr[0], 32'h4);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline. Holds the PC, drives the instruction-memory address, and latches the fetched instruction and PC+4 into IF/ID for decode. It consumes the hazard unit's stall (`FlushSignal`) by freezing PC and IF/ID, and consumes the decode-stage branch/jump redirect by reloading the PC and squashing the wrong-path instruction.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `DELAY_SLOT`, 0, 1 = keep the instruction after a taken branch/jump (MIPS delay slot); 0 = squash it to NOP.
- `CNT_W`, 16, width of the performance counters.

- `Clk`  in  1  clock, rising edge.
- `Rst`  in  1  asynchronous, active-high reset.
- `FlushSignal`  in  1  hazard-unit stall: hold PC and IF/ID this cycle.
- `BranchTaken`  in  1  decode resolved a taken branch.
- `BranchTarget`  in  32  branch target address.
- `Jump`  in  1  decode holds a jump.
- `JumpTarget`  in  32  jump target address.
- `InstrMemAddr`  out  32  current PC to instruction memory (combinational read).
- `InstrMemData`  in  32  instruction at `InstrMemAddr`, same cycle.
- `IF_ID_Instr`  out  32  registered instruction for decode.
- `IF_ID_PCPlus4`  out  32  registered PC+4 of that instruction.
- `IF_ID_Valid`  out  1  IF/ID holds a real (non-squashed, post-reset) instruction.
- `StallCount`  out  CNT_W  cycles spent stalled since reset, saturating.
- `SquashCount`  out  CNT_W  instructions squashed since reset, saturating.

## Operation
- `InstrMemAddr` = PC (combinational). PC, IF/ID and counters update only on the rising edge of `Clk`.
- Per-cycle priority, highest first:
  - **STALL** (`FlushSignal`=1): PC, `IF_ID_Instr`, `IF_ID_PCPlus4` and `IF_ID_Valid` hold. `StallCount`+1. `BranchTaken` and `Jump` are ignored: the decode instruction is the stalled one and its operands are not yet valid.
  - **REDIRECT** (`Jump`=1 or `BranchTaken`=1): PC ← `JumpTarget` if `Jump`, else `BranchTarget`. `Jump` wins if both are high.
    - DELAY_SLOT=0: IF/ID ← NOP (32'h0), PC+4 field 0, `IF_ID_Valid`=0, `SquashCount`+1.
    - DELAY_SLOT=1: IF/ID ← {`InstrMemData`, PC+4}, `IF_ID_Valid`=1.
  - **RUN**: PC ← PC+4; IF/ID ← {`InstrMemData`, PC+4}; `IF_ID_Valid`=1.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. Targets are taken verbatim; the low 2 bits are not checked.
- Counters saturate at 2^CNT_W−1 and do not wrap.

## Timing
- Reset (async, takes effect immediately):
  - PC=`RESET_PC`
  - `IF_ID_Instr`=0, `IF_ID_PCPlus4`=0, `IF_ID_Valid`=0
  - both counters 0
- First cycle after `Rst` deasserts: `InstrMemAddr`=`RESET_PC`. The first instruction appears in IF/ID one edge later.
- Latency: an instruction at address A is in IF/ID one edge after PC=A, absent stall.
- Redirect latency: target address is on `InstrMemAddr` the cycle after the redirect. The target instruction reaches IF/ID one edge later.
- A stall lasting N cycles adds exactly N cycles and loses no instruction.
- Stall and redirect in the same cycle: the stall wins. The redirect must be re-presented by decode after the stall releases.
- Reset asserted mid-stall or mid-redirect: reset state wins, and no pending redirect survives it.

## Structure
- Shared pipeline package holds:
  - `NOP_INSTR` = 32'h0000_0000
  - default `RESET_PC`
  - a 2-bit fetch-action enum {RUN, STALL, REDIRECT} for bench visibility
- Sub-module `pc_register`: PC flop with async reset, hold enable and load mux (next PC select). IF/ID register, squash logic and counters stay in `fetch_stage`.

## Test plan
- **Reset/run:** `Rst` pulse, memory returns address-tagged words, no stall → `InstrMemAddr` sequences 0,4,8,… Word from address 0 appears in IF/ID with `IF_ID_PCPlus4`=4 one edge later, and `IF_ID_Valid` becomes 1.
- **Stall:** at PC=8, hold `FlushSignal`=1 for 2 cycles → PC stays 8 and IF/ID holds the address-4 word. `StallCount`=2, then fetch resumes at 8 with no skipped or duplicated instruction.
- **Branch squash:** DELAY_SLOT=0, `BranchTaken`=1, `BranchTarget`=32'h40 at PC=12 → next `InstrMemAddr`=32'h40, IF/ID=NOP with `IF_ID_Valid`=0, `SquashCount`=1.
- **Delay slot:** DELAY_SLOT=1, same stimulus → IF/ID holds the address-12 word with `IF_ID_Valid`=1, then the 32'h40 word follows.
- **Collisions:** `FlushSignal`=1 with `BranchTaken`=1 → PC unchanged. `Jump`=1 with `BranchTaken`=1, `JumpTarget`=32'h100, `BranchTarget`=32'h40 → PC=32'h100.
- **Wrap/saturation/reset:** RESET_PC=32'hFFFF_FFFC → second fetch address is 0. Force 2^CNT_W+5 stall cycles → `StallCount` saturates at all-ones. Assert `Rst` mid-stall → all outputs reach reset values immediately, before the next edge.
